// File: rtl/lane_spawn_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// lane_spawn_scheduler_pkg
// Shared game definitions for the lane spawn scheduler.
//   state_t          : scheduler FSM states
//   DEF_NUM_LANES    : default number of traffic lanes
//   DEF_DELAY_MULT   : default frames of delay per unit of random value
//   RAND_MIN/MAX     : legal range of the random generator (values outside
//                      are clamped to it)
//   LANE_NONE        : "no previous lane" marker held in last_lane
//   clamp_rand()     : maps a raw 4-bit random value onto RAND_MIN..RAND_MAX
// ---------------------------------------------------------------------------
package lane_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PICK = 2'd2,
        REQ  = 2'd3
    } state_t;

    localparam int DEF_NUM_LANES  = 6;
    localparam int DEF_DELAY_MULT = 4;

    localparam logic [3:0] RAND_MIN  = 4'd1;
    localparam logic [3:0] RAND_MAX  = 4'd12;

    // Never a legal lane, so the first spawn after reset can never match it.
    localparam logic [3:0] LANE_NONE = 4'hF;

    function automatic logic [3:0] clamp_rand(input logic [3:0] r);
        logic [3:0] rc;
        if (r < RAND_MIN) begin
            rc = RAND_MIN;
        end else if (r > RAND_MAX) begin
            rc = RAND_MAX;
        end else begin
            rc = r;
        end
        return rc;
    endfunction

endpackage

// File: rtl/lane_spawn_scheduler_frame_countdown.sv
// ---------------------------------------------------------------------------
// frame_countdown
// 6-bit frame down-counter used as the spawn delay timer.
//   clk          : system clock
//   resetN       : asynchronous active-low reset, clears the count
//   i_load       : load i_load_val (takes priority over decrement)
//   i_load_val   : delay in frames
//   i_run        : counter is armed (scheduler is waiting)
//   i_sof        : start-of-frame pulse; decrements while armed
//   o_terminal   : this frame pulse is the one that finds the count at 1
// ---------------------------------------------------------------------------
module frame_countdown (
    input  logic       clk,
    input  logic       resetN,
    input  logic       i_load,
    input  logic [5:0] i_load_val,
    input  logic       i_run,
    input  logic       i_sof,
    output logic       o_terminal
);

    logic [5:0] r_count;
    logic       w_dec;

    assign w_dec      = i_run && i_sof;
    assign o_terminal = w_dec && (r_count == 6'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (w_dec && (r_count != 6'd0)) begin
            // Holding at zero keeps a stray pulse from wrapping to 63.
            r_count <= r_count - 6'd1;
        end
    end

endmodule

// File: rtl/lane_spawn_scheduler.sv
// ---------------------------------------------------------------------------
// lane_spawn_scheduler
// Decides when and in which lane the next traffic object appears.  A random
// delay (in frames) is counted down, then a lane is chosen from the random
// value, avoiding an immediate repeat of the previous lane, and a spawn
// request is held until the object drawer acknowledges it.
//
// Parameters
//   NUM_LANES    : number of lanes (2..12)
//   DELAY_MULT   : frames of delay per unit of clamped random value (1..5)
// Ports
//   clk          : system clock
//   resetN       : asynchronous active-low reset
//   startOfFrame : one-clock pulse per video frame
//   game_active  : level, high while gameplay runs
//   random       : raw pseudo-random value (clamped to 1..12 internally)
//   spawn_ack    : drawer accepts the pending spawn
//   spawn_req    : a spawn is pending
//   spawn_lane   : target lane of the pending/last spawn
//   spawn_count  : accepted spawns since reset, saturating at 255
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | gameplay stopped; nothing counted, nothing requested
// WAIT  | counting frame pulses down to the next spawn
// PICK  | single cycle: choose and register the lane
// REQ   | spawn_req high, lane frozen, waiting for spawn_ack
// ---------------------------------------------------------------------------
module lane_spawn_scheduler
    import lane_spawn_scheduler_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int DELAY_MULT = DEF_DELAY_MULT
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       game_active,
    input  logic [3:0] random,
    input  logic       spawn_ack,
    output logic       spawn_req,
    output logic [3:0] spawn_lane,
    output logic [7:0] spawn_count
);

    localparam logic [3:0] LANES4 = 4'(NUM_LANES);
    localparam logic [5:0] MULT6  = 6'(DELAY_MULT);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_spawn_lane;
    logic [3:0] r_last_lane;
    logic [7:0] r_spawn_count;

    logic [3:0] w_rc;
    logic [3:0] w_rc_m1;
    logic [3:0] w_cand;
    logic [3:0] w_pick_lane;
    logic [5:0] w_load_val;
    logic       w_count_run;
    logic       w_terminal;
    logic       w_load;
    logic       w_lane_we;
    logic       w_count_inc;

    // -----------------------------------------------------------------------
    // Random value handling: clamp, delay length and lane choice
    // -----------------------------------------------------------------------
    assign w_rc       = clamp_rand(random);
    assign w_rc_m1    = w_rc - 4'd1;
    assign w_cand     = w_rc_m1 % LANES4;
    assign w_load_val = 6'(w_rc) * MULT6;

    // A candidate equal to the previous lane is bumped to the next lane so
    // two consecutive objects never share a lane.
    always_comb begin
        w_pick_lane = w_cand;
        if (w_cand == r_last_lane) begin
            if (r_last_lane >= (LANES4 - 4'd1)) begin
                w_pick_lane = 4'd0;
            end else begin
                w_pick_lane = r_last_lane + 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame delay timer
    // -----------------------------------------------------------------------
    assign w_count_run = game_active && (r_state == WAIT);

    frame_countdown u_frame_countdown (
        .clk        (clk),
        .resetN     (resetN),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_count_run),
        .i_sof      (startOfFrame),
        .o_terminal (w_terminal)
    );

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_lane_we    = 1'b0;
        w_count_inc  = 1'b0;

        // Dropping game_active wins over everything, including an ack
        // arriving in the same cycle.
        if (!game_active) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_load       = 1'b1;
                    w_next_state = WAIT;
                end
                WAIT: begin
                    if (w_terminal) begin
                        w_next_state = PICK;
                    end
                end
                PICK: begin
                    w_lane_we    = 1'b1;
                    w_next_state = REQ;
                end
                REQ: begin
                    if (spawn_ack) begin
                        w_count_inc  = 1'b1;
                        w_load       = 1'b1;
                        w_next_state = WAIT;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Lane and spawn counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_spawn_lane <= 4'd0;
            r_last_lane  <= LANE_NONE;
        end else if (w_lane_we) begin
            r_spawn_lane <= w_pick_lane;
            r_last_lane  <= w_pick_lane;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_spawn_count <= 8'd0;
        end else if (w_count_inc && (r_spawn_count != 8'hFF)) begin
            r_spawn_count <= r_spawn_count + 8'd1;
        end
    end

    // The request is a pure decode of REQ so a reset or an ack drops it
    // together with the state change.
    assign spawn_req   = (r_state == REQ);
    assign spawn_lane  = r_spawn_lane;
    assign spawn_count = r_spawn_count;

endmodule

// File: tb/tb_lane_spawn_scheduler.sv
module tb_lane_spawn_scheduler;

    localparam int NL = 6;
    localparam int DM = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       game_active;
    logic [3:0] random;
    logic       spawn_ack;
    logic       spawn_req;
    logic [3:0] spawn_lane;
    logic [7:0] spawn_count;

    always #5 clk = ~clk;

    lane_spawn_scheduler #(
        .NUM_LANES  (NL),
        .DELAY_MULT (DM)
    ) u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .game_active  (game_active),
        .random       (random),
        .spawn_ack    (spawn_ack),
        .spawn_req    (spawn_req),
        .spawn_lane   (spawn_lane),
        .spawn_count  (spawn_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_last   = -1;
    int m_lane   = 0;
    int m_count  = 0;
    int m_frames = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_r(input int r);
        if (r == 0) return 1;
        if (r > 12) return 12;
        return r;
    endfunction

    function automatic int pick_lane(input int r);
        int cand;
        cand = (clamp_r(r) - 1) % NL;
        if (cand == m_last) cand = (m_last + 1) % NL;
        return cand;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input int r);
        game_active = 1'b1;
        random      = 4'(r);
        step();
        m_frames = clamp_r(r) * DM;
    endtask

    // DUT sits in the delay phase with m_frames loaded.  Deliver all but the
    // last frame pulse, confirm no early request, then the terminal pulse
    // and the two-clock latency to the request.
    task automatic run_frames(input int r_pick);
        for (int i = 1; i < m_frames; i++) begin
            startOfFrame = 1'b1;
            random       = 4'($urandom_range(0, 15));
            spawn_ack    = 1'($urandom_range(0, 1));
            step();
            startOfFrame = 1'b0;
            repeat ($urandom_range(0, 1)) step();
        end
        spawn_ack = 1'b0;
        step();
        step();
        check("no_early_req", int'(spawn_req), 0);

        startOfFrame = 1'b1;
        random       = 4'(r_pick);
        spawn_ack    = 1'($urandom_range(0, 1));
        step();
        startOfFrame = 1'b0;
        check("lat1_req", int'(spawn_req), 0);
        step();
        spawn_ack = 1'b0;
        check("lat2_req", int'(spawn_req), 1);
        m_lane = pick_lane(r_pick);
        m_last = m_lane;
        check("pick_lane", int'(spawn_lane), m_lane);
        check("count_hold", int'(spawn_count), m_count);
    endtask

    task automatic handshake(input int hold, input int r_next);
        for (int i = 0; i < hold; i++) begin
            random       = 4'($urandom_range(0, 15));
            startOfFrame = 1'($urandom_range(0, 1));
            step();
            check("req_held", int'(spawn_req), 1);
            check("lane_stable", int'(spawn_lane), m_lane);
        end
        startOfFrame = 1'b0;
        spawn_ack    = 1'b1;
        random       = 4'(r_next);
        step();
        spawn_ack = 1'b0;
        check("ack_drop", int'(spawn_req), 0);
        if (m_count < 255) m_count++;
        check("spawn_count", int'(spawn_count), m_count);
        m_frames = clamp_r(r_next) * DM;
    endtask

    task automatic abort_in_req();
        game_active = 1'b0;
        spawn_ack   = 1'b1;
        step();
        check("abort_req", int'(spawn_req), 0);
        check("abort_count", int'(spawn_count), m_count);
        startOfFrame = 1'b1;
        step();
        step();
        startOfFrame = 1'b0;
        check("idle_req", int'(spawn_req), 0);
        check("idle_count", int'(spawn_count), m_count);
        spawn_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, int'(spawn_req), 0);
        check({tag, "_lane"}, int'(spawn_lane), 0);
        check({tag, "_count"}, int'(spawn_count), 0);
        m_last  = -1;
        m_lane  = 0;
        m_count = 0;
    endtask

    task automatic release_reset();
        game_active = 1'b0;
        spawn_ack   = 1'b0;
        step();
        step();
        resetN = 1'b1;
        step();
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        game_active  = 1'b0;
        random       = 4'd0;
        spawn_ack    = 1'b0;
        #1;
        check_reset_outputs("por");
        release_reset();

        // Frame pulses before gameplay starts must not load or count.
        repeat (3) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
        check("pre_game_req", int'(spawn_req), 0);

        // random=3: 12 frames, lane 2
        start_game(3);
        check("frames_r3", m_frames, 12);
        run_frames(3);
        handshake(0, 5);

        // Two spawns with random=5: lane 4 then 5
        run_frames(5);
        handshake(2, 5);
        run_frames(5);
        handshake(1, 15);

        // random=15 load (48 frames), random=0 pick -> lane 0; long hold
        run_frames(0);
        handshake(9, 7);

        // Abort with simultaneous ack during the request
        run_frames($urandom_range(0, 15));
        abort_in_req();
        start_game($urandom_range(0, 15));
        run_frames($urandom_range(0, 15));
        handshake(1, 2);

        // Asynchronous reset while waiting
        repeat (2) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
        end
        #3 resetN = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        release_reset();
        start_game($urandom_range(0, 15));
        run_frames($urandom_range(0, 15));
        handshake($urandom_range(0, 3), $urandom_range(0, 15));

        // Randomized spawns with occasional aborts
        for (int s = 0; s < 30; s++) begin
            run_frames($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                abort_in_req();
                start_game($urandom_range(0, 15));
            end else begin
                handshake($urandom_range(0, 4), $urandom_range(0, 15));
            end
        end

        // Asynchronous reset during a pending request
        run_frames($urandom_range(0, 15));
        step();
        spawn_ack = 1'b1;
        #3 resetN = 1'b0;
        #1;
        check_reset_outputs("rst_req");
        release_reset();

        // Saturation of the spawn counter
        start_game($urandom_range(0, 15));
        for (int s = 0; s < 258; s++) begin
            run_frames($urandom_range(0, 15));
            handshake($urandom_range(0, 1), $urandom_range(0, 15));
        end
        check("sat_count", int'(spawn_count), 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lane_spawn_scheduler.md
LANE_SPAWN_SCHEDULER -- requirements
Module: lane_spawn_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 6, giving the number of traffic lanes (legal range 2..12).
REQ-002 The block SHALL have parameter DELAY_MULT, default 4, giving the frames of delay per unit of random value (legal range 1..5).
REQ-003 Port clk, input, 1 bit: the single system clock.
REQ-004 Port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port startOfFrame, input, 1 bit: one-clk pulse per video frame.
REQ-006 Port game_active, input, 1 bit: level input; high while gameplay runs.
REQ-007 Port random, input, 4 bits: pseudo-random value from the 1..12 generator.
REQ-008 Port spawn_ack, input, 1 bit: the object drawer accepts the pending spawn.
REQ-009 Port spawn_req, output, 1 bit: a spawn is pending.
REQ-010 Port spawn_lane, output, 4 bits: target lane, 0..NUM_LANES-1.
REQ-011 Port spawn_count, output, 8 bits: accepted spawns since reset, saturating.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, WAIT, PICK and REQ.
REQ-013 Clamp rule: random value r SHALL be used as rc, where r=0 gives rc=1, r>12 gives rc=12, and any other r gives rc=r.
REQ-014 From IDLE, game_active=1 SHALL cause a move to WAIT, with the frame counter loaded with rc*DELAY_MULT (6-bit counter, minimum 1).
REQ-015 In WAIT, each startOfFrame SHALL decrement the counter; the startOfFrame pulse that finds counter==1 SHALL cause a move to PICK on the next edge.
REQ-016 In PICK (one cycle), the candidate lane SHALL be (rc-1) mod NUM_LANES. If the candidate equals last_lane, the lane SHALL be last_lane+1, wrapping to 0 past NUM_LANES-1. The result SHALL be registered into spawn_lane and last_lane, then the FSM SHALL move to REQ.
REQ-017 In REQ, spawn_req SHALL be 1 and spawn_lane SHALL be held stable until spawn_ack=1 is sampled.
REQ-018 On an ack sampled in REQ: spawn_req SHALL drop on the same edge, spawn_count SHALL increment (saturating at 255), and the FSM SHALL return to WAIT with the counter reloaded from the current rc.
REQ-019 An ack sampled in the first REQ cycle SHALL be honoured, giving a minimum req pulse of 1 cycle.
REQ-020 spawn_ack SHALL be ignored in IDLE, WAIT and PICK.
REQ-021 game_active=0 in any state SHALL force IDLE on the next edge, clear spawn_req, and count no spawn, even if spawn_ack=1 in the same cycle.
REQ-022 game_active=0 SHALL leave spawn_count and last_lane unchanged.
REQ-023 startOfFrame in a state other than WAIT SHALL have no effect.
REQ-024 Latency from the terminal startOfFrame to spawn_req=1 SHALL be exactly 2 clk.

Reset
REQ-025 Asserting resetN low SHALL force, asynchronously: state IDLE, spawn_req 0, spawn_lane 0, spawn_count 0, counter 0, last_lane 4'hF (no match on the first spawn).
REQ-026 Reset asserted mid-handshake SHALL drop spawn_req immediately, with no spawn counted.
REQ-027 After resetN is released, the block SHALL wait for game_active before loading any delay.

Structure
REQ-028 The state enum typedef, the default NUM_LANES and DELAY_MULT, and the clamp limits 1 and 12 SHALL live in the shared game package.
REQ-029 The down-counter SHALL be a sub-module frame_countdown (load, startOfFrame-gated decrement, terminal flag). Everything else SHALL remain in lane_spawn_scheduler.

Verification
REQ-030 Reset, then game_active=1 with random=3 and DELAY_MULT=4 -> exactly 12 startOfFrame pulses, then 2 clk later spawn_req=1 with spawn_lane=2.
REQ-031 Two consecutive spawns, each with random=5 at PICK -> spawn_lane 4 then 5 (repeat avoided), spawn_count=2.
REQ-032 random=15 at load and random=0 at PICK -> delay 48 frames, then spawn_lane=0.
REQ-033 spawn_req held for 10 cycles with no ack, with random toggling -> spawn_lane constant. Ack in cycle 10 -> req drops next edge and count increments by 1.
REQ-034 game_active=0 in the same cycle as spawn_ack during REQ -> IDLE, spawn_req=0, spawn_count unchanged. Separately, resetN pulsed low in WAIT -> all outputs reach their reset values with no clk edge.
REQ-035 256 acknowledged spawns -> spawn_count stays at 255.
